// File: rtl/instr_prefetch_queue_if.sv
// Bus bundle for the instruction prefetch queue: the instruction-memory
// request/grant/response port, the IF/ID valid/ready port and the
// taken-branch redirect input.
//
// Handshake semantics:
//   mem:  mem_req/mem_addr are held stable until mem_gnt is seen high at a
//         rising edge. Exactly one response (mem_rvalid) follows each grant,
//         at the earliest one cycle later, and never in a grant cycle.
//   out:  an entry transfers on a rising edge where out_valid && out_ready
//         (and no redirect). out_instr/out_pc stay stable while out_valid
//         is high and out_ready is low.
interface instr_prefetch_queue_if;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;

  logic        redirect_valid;
  logic [63:0] redirect_pc;

  // The prefetch queue itself
  modport master (
    output mem_req, mem_addr, out_valid, out_instr, out_pc,
    input  mem_gnt, mem_rvalid, mem_rdata, out_ready,
           redirect_valid, redirect_pc
  );

  // Memory, IF/ID stage and branch unit around it
  modport slave (
    input  mem_req, mem_addr, out_valid, out_instr, out_pc,
    output mem_gnt, mem_rvalid, mem_rdata, out_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words from instruction
// memory with a single outstanding request, buffers {instr, pc} pairs in a
// DEPTH-entry FIFO and hands them to IF/ID. A taken-branch redirect flushes
// the FIFO and restarts fetching at the target; a response that was already
// in flight when the redirect hit is dropped via the discard flag.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic                       clk,
  input  logic                       reset,      // async, active-low
  instr_prefetch_queue_if.master     bus,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [1:0]                 dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e             state_q,    state_d;
  logic [63:0]        fetch_pc_q, fetch_pc_d;
  logic [63:0]        req_pc_q,   req_pc_d;
  logic [63:0]        mem_addr_q, mem_addr_d;
  logic               mem_req_q,  mem_req_d;
  logic               discard_q,  discard_d;
  logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [OCC_W-1:0]   count_q,    count_d;

  logic [31:0]        instr_mem_q [DEPTH];
  logic [63:0]        pc_mem_q    [DEPTH];

  logic               redirect;
  logic               rsp_fire;
  logic               push;
  logic               pop;
  logic               out_valid;

  // The two low bits of the branch target are forced to zero (word fetch)
  logic               unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  assign redirect  = bus.redirect_valid;
  assign out_valid = (count_q != '0);
  assign rsp_fire  = (state_q == S_WAIT) && bus.mem_rvalid;
  assign push      = rsp_fire && !discard_q && !redirect;
  assign pop       = out_valid && bus.out_ready && !redirect;

  // Next-state logic for the fetch FSM, the PC registers and the FIFO pointers
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    // Grant: remember the address actually issued; fetch_pc may already
    // point at a redirect target by now.
    if (state_q == S_REQ && bus.mem_gnt) begin
      state_d  = S_WAIT;
      req_pc_d = mem_addr_q;
    end

    if (push) begin
      fetch_pc_d = req_pc_q + 64'd4;
    end

    // A response always retires the discard flag, used or not
    if (rsp_fire) begin
      discard_d = 1'b0;
    end

    // Redirect: retarget, and mark any request that is still to answer.
    // A response landing in the redirect cycle is simply not pushed.
    if (redirect) begin
      fetch_pc_d = {bus.redirect_pc[63:2], 2'b00};
      if (state_q == S_REQ || (state_q == S_WAIT && !bus.mem_rvalid)) begin
        discard_d = 1'b1;
      end
    end

    // FIFO bookkeeping; redirect wins over push and pop
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end

    // Issue only when the slot for the returning word is guaranteed
    if (state_q == S_IDLE && count_d < DEPTH_C) begin
      state_d = S_REQ;
    end
    if (rsp_fire) begin
      state_d = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
    end

    // Request outputs are registered; the address is loaded on REQ entry
    // and then held until the grant
    mem_req_d  = (state_d == S_REQ);
    mem_addr_d = (state_d == S_REQ && state_q != S_REQ) ? fetch_pc_d : mem_addr_q;
  end

  // Control registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      discard_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      discard_q  <= discard_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads as zero afterwards
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= bus.mem_rdata;
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = instr_mem_q[rd_ptr_q];
  assign bus.out_pc    = pc_mem_q[rd_ptr_q];
  assign occupancy     = count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: a behavioural instruction memory
// with programmable response latency and grant hold, plus a linear sequence
// of directed steps checked with immediate assertions.
module tb_instr_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'd0;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_REQ   = 2'd1;
  localparam logic [1:0]  ST_WAIT  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instr_prefetch_queue_if bus();
  logic [2:0] occupancy;
  logic [1:0] dbg_state;

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .occupancy (occupancy),
    .dbg_state (dbg_state)
  );

  // ---------------- memory model ----------------
  int          rsp_lat      = 1;
  logic        gnt_hold     = 1'b0;
  logic        rsp_gnt      = 1'b0;
  logic        rsp_rvalid   = 1'b0;
  logic [31:0] rsp_rdata    = '0;
  logic        rsp_pending  = 1'b0;
  int          rsp_cnt      = 0;
  logic [63:0] rsp_addr     = '0;
  logic [63:0] gnt_addr     = '0;
  logic        stray_rvalid = 1'b0;
  logic [31:0] stray_rdata  = '0;
  logic [63:0] issued_q[$];
  logic [63:0] exp_q[$];

  assign bus.mem_gnt    = rsp_gnt;
  assign bus.mem_rvalid = rsp_rvalid | stray_rvalid;
  assign bus.mem_rdata  = stray_rvalid ? stray_rdata : rsp_rdata;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    if (a == 64'd0) return 32'h00500093;
    if (a == 64'd4) return 32'h00100113;
    return {8'hE0, a[23:0]};
  endfunction

  // Memory: grant when requested and idle, answer rsp_lat cycles later
  always @(negedge clk) begin
    if (rsp_rvalid) rsp_pending = 1'b0;
    if (rsp_gnt) begin
      rsp_pending = 1'b1;
      rsp_cnt     = rsp_lat;
      rsp_addr    = gnt_addr;
    end
    rsp_rvalid = 1'b0;
    rsp_gnt    = 1'b0;
    if (!reset) begin
      rsp_pending = 1'b0;
    end else begin
      if (rsp_pending) begin
        if (rsp_cnt <= 1) begin
          rsp_rvalid = 1'b1;
          rsp_rdata  = instr_of(rsp_addr);
        end else begin
          rsp_cnt = rsp_cnt - 1;
        end
      end
      if (bus.mem_req && !gnt_hold && !rsp_pending) begin
        rsp_gnt  = 1'b1;
        gnt_addr = bus.mem_addr;
        issued_q.push_back(bus.mem_addr);
      end
    end
  end

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset              = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    gnt_hold           = 1'b0;
    stray_rvalid       = 1'b0;
    tick();
    tick();
    issued_q.delete();
    reset = 1'b1;
  endtask

  task automatic wait_valid(input int max, input string tag);
    for (int i = 0; i < max && !bus.out_valid; i++) tick();
    check(tag, bus.out_valid, 1'b1);
  endtask

  task automatic redirect_one(input logic [63:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // --- reset state ---
    rsp_lat = 1;
    do_reset();
    reset = 1'b0;
    tick();
    check("rst_mem_req",   bus.mem_req,   1'b0);
    check("rst_mem_addr",  bus.mem_addr,  RESET_PC);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_instr", bus.out_instr, 32'h0);
    check("rst_out_pc",    bus.out_pc,    64'h0);
    check("rst_occupancy", occupancy,     3'd0);
    check("rst_state",     dbg_state,     ST_IDLE);

    // --- T1: streaming with out_ready=1 ---
    do_reset();
    bus.out_ready = 1'b1;
    wait_valid(20, "t1_first_valid");
    check("t1_first_pc",    bus.out_pc,    64'h0);
    check("t1_first_instr", bus.out_instr, 32'h00500093);
    tick();
    wait_valid(20, "t1_second_valid");
    check("t1_second_pc",    bus.out_pc,    64'h4);
    check("t1_second_instr", bus.out_instr, 32'h00100113);
    for (int i = 0; i < 20 && issued_q.size() < 3; i++) tick();
    exp_q = '{64'h0, 64'h4, 64'h8};
    check("t1_issue_count", 64'(issued_q.size() >= 3), 64'd1);
    for (int i = 0; i < 3 && i < issued_q.size(); i++) begin
      check($sformatf("t1_mem_addr%0d", i), issued_q[i], exp_q[i]);
    end

    // --- T2: fill to DEPTH with out_ready=0, then one pop ---
    do_reset();
    for (int i = 0; i < 14; i++) tick();
    check("t2_full_occ",   occupancy,     3'd4);
    check("t2_full_req",   bus.mem_req,   1'b0);
    check("t2_full_state", dbg_state,     ST_IDLE);
    check("t2_full_pc",    bus.out_pc,    64'h0);
    check("t2_full_instr", bus.out_instr, 32'h00500093);
    check("t2_full_issued", 64'(issued_q.size()), 64'd4);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t2_pop_occ",   occupancy,   3'd3);
    check("t2_pop_req",   bus.mem_req, 1'b1);
    check("t2_pop_addr",  bus.mem_addr, 64'h10);
    check("t2_pop_pc",    bus.out_pc,  64'h4);
    for (int i = 0; i < 6; i++) tick();
    check("t2_refill_occ",    occupancy,   3'd4);
    check("t2_refill_req",    bus.mem_req, 1'b0);
    check("t2_refill_issued", 64'(issued_q.size()), 64'd5);
    check("t2_refill_pc",     bus.out_pc,  64'h4);

    // --- T3: redirect to 0x103 while waiting on addr 8 ---
    rsp_lat = 3;
    do_reset();
    for (int i = 0; i < 40 && !(dbg_state == ST_WAIT && bus.mem_addr == 64'h8); i++) tick();
    check("t3_in_wait8", dbg_state, ST_WAIT);
    check("t3_occ_before", occupancy, 3'd2);
    redirect_one(64'h103);
    check("t3_flush_occ",   occupancy,     3'd0);
    check("t3_flush_valid", bus.out_valid, 1'b0);
    for (int i = 0; i < 10 && !bus.mem_req; i++) tick();
    check("t3_req_after", bus.mem_req,  1'b1);
    check("t3_new_addr",  bus.mem_addr, 64'h100);
    bus.out_ready = 1'b1;
    wait_valid(20, "t3_valid");
    check("t3_out_pc",    bus.out_pc,    64'h100);
    check("t3_out_instr", bus.out_instr, 32'hE0000100);

    // --- T4: redirect coinciding with mem_rvalid and out_ready ---
    rsp_lat = 1;
    do_reset();
    for (int i = 0; i < 30 && !(occupancy == 3'd2 && dbg_state == ST_WAIT); i++) tick();
    check("t4_setup_occ", occupancy, 3'd2);
    bus.out_ready = 1'b1;
    redirect_one(64'h200);
    check("t4_occ",      occupancy,     3'd0);
    check("t4_valid",    bus.out_valid, 1'b0);
    check("t4_req",      bus.mem_req,   1'b1);
    check("t4_addr",     bus.mem_addr,  64'h200);
    check("t4_state",    dbg_state,     ST_REQ);
    wait_valid(20, "t4_next_valid");
    check("t4_next_pc",  bus.out_pc,    64'h200);

    // --- T5: grant withheld across a redirect to 0x40 ---
    do_reset();
    bus.out_ready = 1'b1;
    gnt_hold      = 1'b1;
    tick();
    check("t5_req",  bus.mem_req,  1'b1);
    check("t5_addr", bus.mem_addr, 64'h0);
    tick();
    redirect_one(64'h40);
    check("t5_hold_addr",  bus.mem_addr, 64'h0);
    check("t5_hold_req",   bus.mem_req,  1'b1);
    check("t5_hold_state", dbg_state,    ST_REQ);
    tick();
    tick();
    check("t5_hold_addr2", bus.mem_addr, 64'h0);
    gnt_hold = 1'b0;
    wait_valid(20, "t5_valid");
    check("t5_out_pc",    bus.out_pc,    64'h40);
    check("t5_out_instr", bus.out_instr, 32'hE0000040);
    check("t5_issue0", (issued_q.size() > 0) ? issued_q[0] : 64'hX, 64'h0);
    check("t5_issue1", (issued_q.size() > 1) ? issued_q[1] : 64'hX, 64'h40);

    // --- T6: asynchronous reset in WAIT with three entries ---
    rsp_lat = 3;
    do_reset();
    for (int i = 0; i < 40 && !(occupancy == 3'd3 && dbg_state == ST_WAIT); i++) tick();
    check("t6_setup_occ", occupancy, 3'd3);
    reset = 1'b0;
    #1;
    check("t6_async_req",   bus.mem_req,   1'b0);
    check("t6_async_addr",  bus.mem_addr,  RESET_PC);
    check("t6_async_valid", bus.out_valid, 1'b0);
    check("t6_async_instr", bus.out_instr, 32'h0);
    check("t6_async_pc",    bus.out_pc,    64'h0);
    check("t6_async_occ",   occupancy,     3'd0);
    check("t6_async_state", dbg_state,     ST_IDLE);
    stray_rvalid = 1'b1;
    stray_rdata  = 32'hDEADBEEF;
    tick();
    tick();
    issued_q.delete();
    reset = 1'b1;
    tick();
    stray_rvalid = 1'b0;
    check("t6_rel_occ",   occupancy,    3'd0);
    check("t6_rel_req",   bus.mem_req,  1'b1);
    check("t6_rel_addr",  bus.mem_addr, RESET_PC);
    wait_valid(20, "t6_valid");
    check("t6_first_pc",    bus.out_pc,    64'h0);
    check("t6_first_instr", bus.out_instr, 32'h00500093);
    check("t6_first_occ",   occupancy,     3'd1);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound in case a step misbehaves
  initial begin
    #200000;
    $display("FAIL watchdog expired: observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Instruction fetch front end between the instruction-memory port and the IF/ID pipeline register.
- Generates sequential fetch addresses and issues single-outstanding requests to instruction memory over a request/grant/response handshake.
- Buffers returned instructions with their PCs in a FIFO of DEPTH entries, then presents them to IF/ID with a valid/ready handshake.
- Flushes and restarts on a taken-branch redirect from the MEM stage.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- RESET_PC, 64'd0, first fetch address after reset

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- mem_req  output  1  fetch request valid
- mem_addr  output  64  fetch byte address, word aligned
- mem_gnt  input  1  request accepted this cycle
- mem_rvalid  input  1  response data valid
- mem_rdata  input  32  returned instruction
- out_valid  output  1  FIFO head valid
- out_instr  output  32  head instruction
- out_pc  output  64  head PC
- out_ready  input  1  IF/ID accepts head (driven by IF_ID_Write)
- redirect_valid  input  1  taken branch (to_branch_MEM)
- redirect_pc  input  64  branch target
- occupancy  output  $clog2(DEPTH)+1  valid FIFO entries

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC.
  - out_valid=0, out_instr=0, out_pc=0, occupancy=0.
  - FIFO pointers=0, discard=0.
  - FSM=IDLE.
- Reset asserted mid-transaction drops everything. A response arriving during or after reset for a pre-reset request is ignored, because discard is cleared and the FSM is IDLE.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ when occupancy + reserved < DEPTH. reserved = 1 while in REQ/WAIT.
  - REQ: mem_req=1 and mem_addr=fetch_pc. Both are held stable until mem_gnt. On mem_gnt: go to WAIT and latch req_pc=fetch_pc.
  - WAIT: on mem_rvalid:
    - If discard=0: push {mem_rdata, req_pc} and set fetch_pc = req_pc + 4.
    - If discard=1: drop the data and clear discard.
    - Then go to REQ if space remains, else IDLE.
  - mem_rvalid may arrive the cycle after mem_gnt at the earliest. mem_gnt and mem_rvalid in the same cycle is illegal.
- Only one transaction (REQ or WAIT) exists at any time. Maximum throughput is one instruction per 2 cycles with single-cycle memory.
- Pop: occurs when out_valid && out_ready && !redirect_valid. out_instr/out_pc are the FIFO head, registered, and stable while out_valid && !out_ready.
- Push and pop in the same cycle: occupancy is unchanged. Overflow cannot occur because issue reserves space.
- Empty FIFO: out_valid=0. A pushed entry becomes visible the cycle after mem_rvalid (1-cycle fill latency; no bypass).
- Redirect (redirect_valid=1 at a clock edge):
  - FIFO is flushed: occupancy=0, pointers reset, out_valid=0 next cycle.
  - fetch_pc = {redirect_pc[63:2], 2'b00}.
  - If FSM=IDLE: go to REQ next cycle with the new address.
  - If FSM=REQ: the ungranted request keeps its old address until granted, then goes to WAIT with discard=1. A redirect coinciding with mem_gnt also sets discard=1.
  - If FSM=WAIT: set discard=1, unless mem_rvalid arrives this same cycle. In that case the data is dropped and discard stays 0.
  - After a discarded response, the FSM issues fetch_pc, i.e. the redirect target.
  - Redirect has priority over pop and push in the same cycle.
  - Back-to-back redirects: the last one wins. discard is a single flag; at most one response is ever in flight.
- Arithmetic: PC increment is +4 modulo 2^64. Wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0 is legal and silent.

Test Plan:
- Reset release, RESET_PC=0, mem_gnt=1 and mem_rvalid 1 cycle after grant, data 32'h00500093 then 32'h00100113, out_ready=1 -> out_valid rises with out_pc=0, out_instr=32'h00500093. Next entry has out_pc=4. mem_addr sequence is 0,4,8,...
- out_ready=0 with fast memory -> occupancy climbs to 4 and mem_req stays 0 while full. out_pc holds 0. Raising out_ready for 1 cycle -> occupancy 3, and one new request issues.
- Redirect to 64'h103 while in WAIT for addr 8 -> response for 8 dropped. Next mem_addr=64'h100 and the next out_pc=64'h100. FIFO is empty the cycle after the redirect.
- Redirect in the same cycle as mem_rvalid and out_ready with 2 entries queued -> no push, no pop counted, occupancy=0, next request to the target.
- mem_gnt withheld 5 cycles while a redirect to 64'h40 arrives -> mem_addr holds its old value until grant. The response is discarded, then mem_addr=64'h40.
- Assert reset low in WAIT with occupancy=3 -> all outputs take reset values immediately (asynchronously). A later stray mem_rvalid is ignored, and after release the first mem_addr is RESET_PC.
